pc_sequencer: RTL and testbench

//  Parametrised program-counter unit; the successor to the free-running PC.
//  - Selects next PC from: sequential, conditional branch, jump, return.
//  - Supports stall and a circular return-address stack (RAS).
//  - Feeds INSTRUCTION_MEMORY address.
//  - Exports pc_plus4 for link/branch use in the datapath.

---
 rtl/pc_sequencer_pkg.sv | 16 +
 rtl/pc_sequencer_if.sv | 31 +++
 rtl/pc_sequencer_ras.sv | 78 +++++++
 rtl/pc_sequencer.sv | 89 ++++++++
 tb/tb_pc_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Holds the next-PC selector encoding and the instruction-format field widths.
package pc_pkg;

  typedef enum logic [1:0] {
    SEQ    = 2'd0,
    BRANCH = 2'd1,
    JUMP   = 2'd2,
    RETURN = 2'd3
  } pc_sel_t;

  localparam int INSTR_BYTES  = 4;
  localparam int JUMP_FIELD_W = 26;
  localparam int BRANCH_IMM_W = 16;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the decode stage (master) and the PC sequencer (slave).
// Carries next-PC selection inputs and the PC and return-stack status outputs.
interface pc_sequencer_if #(
  parameter int ADDR_W = 32
) ();
  import pc_pkg::*;

  logic              stall;
  pc_sel_t           pc_sel;
  logic              branch_taken;
  logic [15:0]       branch_imm;
  logic [25:0]       jump_target;
  logic              call;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_overflow;
  logic              ras_underflow;

  modport master (
    output stall, pc_sel, branch_taken, branch_imm, jump_target, call,
    input  pc, pc_plus4, ras_empty, ras_full, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, pc_sel, branch_taken, branch_imm, jump_target, call,
    output pc, pc_plus4, ras_empty, ras_full, ras_overflow, ras_underflow
  );

endinterface

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack: a full push overwrites the oldest entry.
// Push and pop together on a non-empty stack replace the top entry in place.
module return_address_stack #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] entries [RAS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  top_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;
  logic              do_replace;

  assign top_ptr = wr_ptr - PTR_W'(1);
  assign top     = entries[top_ptr];
  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);

  // NOTE: every signal driven here gets a value before any branch, so no latch is inferred.
  always_comb begin
    do_push    = 1'b0;
    do_pop     = 1'b0;
    do_replace = 1'b0;
    if (push && pop && !empty) begin
      do_replace = 1'b1;
    end else if (push) begin
      do_push = 1'b1;
    end else if (pop && !empty) begin
      do_pop = 1'b1;
    end
  end

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (full) overflow <= 1'b1;
        else      count    <= count + (PTR_W+1)'(1);
      end else if (do_pop) begin
        wr_ptr <= top_ptr;
        count  <= count - (PTR_W+1)'(1);
      end
      if (pop && empty) underflow <= 1'b1;
    end
  end

  // NOTE: storage is not reset; count gates validity, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      entries[wr_ptr] <= push_data;
    end else if (do_replace) begin
      entries[top_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: selects sequential, branch, jump or return target,
// honours stall, and maintains a return-address stack for call/return.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int          ADDR_W       = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  parameter int          RAS_DEPTH    = 4
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.slave  bus
);

  localparam int JUMP_SPAN = JUMP_FIELD_W + 2;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] branch_offset;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] jump_pc;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_overflow;
  logic              ras_underflow;
  logic              ras_push;
  logic              ras_pop;

  assign pc_plus4      = pc_q + ADDR_W'(INSTR_BYTES);
  assign branch_offset = {{(ADDR_W-BRANCH_IMM_W-2){bus.branch_imm[BRANCH_IMM_W-1]}},
                          bus.branch_imm, 2'b00};
  assign branch_target = pc_plus4 + branch_offset;

  // The jump keeps the region bits above the 28-bit span, which vanish at ADDR_W=28.
  generate
    if (ADDR_W == JUMP_SPAN) begin : g_jump_narrow
      assign jump_pc = {bus.jump_target, 2'b00};
    end else begin : g_jump_wide
      assign jump_pc = {pc_plus4[ADDR_W-1:JUMP_SPAN], bus.jump_target, 2'b00};
    end
  endgenerate

  always_comb begin
    next_pc = pc_plus4;
    case (bus.pc_sel)
      BRANCH:  if (bus.branch_taken) next_pc = branch_target;
      JUMP:    next_pc = jump_pc;
      RETURN:  if (!ras_empty) next_pc = ras_top;
      default: next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= ADDR_W'(RESET_VECTOR);
    end else if (!bus.stall) begin
      pc_q <= next_pc;
    end
  end

  assign ras_push = bus.call && !bus.stall;
  assign ras_pop  = (bus.pc_sel == RETURN) && !bus.stall;

  return_address_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus4),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  assign bus.pc            = pc_q;
  assign bus.pc_plus4      = pc_plus4;
  assign bus.ras_empty     = ras_empty;
  assign bus.ras_full      = ras_full;
  assign bus.ras_overflow  = ras_overflow;
  assign bus.ras_underflow = ras_underflow;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a queue-based reference model predicts
// each cycle's PC and stack flags; a second instance covers a high-region jump/return.
module tb_pc_sequencer;
  import pc_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pp;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic clk;
  logic reset;

  pc_sequencer_if #(.ADDR_W(32)) bus_a ();
  pc_sequencer_if #(.ADDR_W(32)) bus_b ();

  pc_sequencer #(
    .ADDR_W       (32),
    .RESET_VECTOR (32'h0000_0100),
    .RAS_DEPTH    (4)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  pc_sequencer #(
    .ADDR_W       (32),
    .RESET_VECTOR (32'h3000_0010),
    .RAS_DEPTH    (4)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  exp_t        exp_q [$];
  logic [31:0] ras_m [$];
  logic [31:0] m_pc;
  logic        m_ovf;
  logic        m_unf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = 32'h0000_0100;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    ras_m.delete();
  endtask

  task automatic model_step(input logic st, input pc_sel_t sel, input logic tk,
                            input logic [15:0] imm, input logic [25:0] tgt, input logic cl);
    logic [31:0] pp;
    logic [31:0] nxt;
    logic        ret;
    pp  = m_pc + 32'd4;
    nxt = m_pc;
    if (!st) begin
      ret = (sel == RETURN);
      case (sel)
        SEQ:     nxt = pp;
        BRANCH:  nxt = tk ? pp + {{14{imm[15]}}, imm, 2'b00} : pp;
        JUMP:    nxt = {pp[31:28], tgt, 2'b00};
        default: nxt = (ras_m.size() > 0) ? ras_m[$] : pp;
      endcase
      if (ret && cl) begin
        if (ras_m.size() > 0) begin
          ras_m[ras_m.size()-1] = pp;
        end else begin
          ras_m.push_back(pp);
          m_unf = 1'b1;
        end
      end else if (ret) begin
        if (ras_m.size() > 0) void'(ras_m.pop_back());
        else                  m_unf = 1'b1;
      end else if (cl) begin
        if (ras_m.size() == 4) begin
          void'(ras_m.pop_front());
          m_ovf = 1'b1;
        end
        ras_m.push_back(pp);
      end
      m_pc = nxt;
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.pc    = m_pc;
    e.pp    = m_pc + 32'd4;
    e.empty = (ras_m.size() == 0);
    e.full  = (ras_m.size() == 4);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    exp_q.push_back(e);
  endtask

  task automatic compare_a(input string tag);
    exp_t e;
    e = exp_q.pop_front();
    check({tag, ":pc"},       bus_a.pc,            e.pc);
    check({tag, ":pc_plus4"}, bus_a.pc_plus4,      e.pp);
    check({tag, ":empty"},    bus_a.ras_empty,     e.empty);
    check({tag, ":full"},     bus_a.ras_full,      e.full);
    check({tag, ":ovf"},      bus_a.ras_overflow,  e.ovf);
    check({tag, ":unf"},      bus_a.ras_underflow, e.unf);
  endtask

  task automatic step(input string tag, input logic st, input pc_sel_t sel, input logic tk,
                      input logic [15:0] imm, input logic [25:0] tgt, input logic cl);
    bus_a.stall        = st;
    bus_a.pc_sel       = sel;
    bus_a.branch_taken = tk;
    bus_a.branch_imm   = imm;
    bus_a.jump_target  = tgt;
    bus_a.call         = cl;
    model_step(st, sel, tk, imm, tgt, cl);
    push_expected();
    @(posedge clk);
    #1;
    compare_a(tag);
  endtask

  initial begin
    bus_a.stall = 1'b0; bus_a.pc_sel = SEQ; bus_a.branch_taken = 1'b0;
    bus_a.branch_imm = '0; bus_a.jump_target = '0; bus_a.call = 1'b0;
    bus_b.stall = 1'b1; bus_b.pc_sel = SEQ; bus_b.branch_taken = 1'b0;
    bus_b.branch_imm = '0; bus_b.jump_target = '0; bus_b.call = 1'b0;
    reset = 1'b1;
    model_reset();

    // Reset state
    #11;
    push_expected();
    compare_a("reset");
    check("b_reset:pc", bus_b.pc, 32'h3000_0010);
    #1 reset = 1'b0;

    // Sequential run
    for (int i = 0; i < 3; i++) step($sformatf("seq%0d", i), 1'b0, SEQ, 1'b0, '0, '0, 1'b0);
    check("seq_final", bus_a.pc, 32'h0000_010C);

    // Conditional branch, taken and not taken, from 0x200
    step("jmp200a", 1'b0, JUMP, 1'b0, '0, 26'h80, 1'b0);
    step("br_tk", 1'b0, BRANCH, 1'b1, 16'hFFFE, '0, 1'b0);
    check("br_tk_val", bus_a.pc, 32'h0000_01FC);
    step("jmp200b", 1'b0, JUMP, 1'b0, '0, 26'h80, 1'b0);
    step("br_nt", 1'b0, BRANCH, 1'b0, 16'hFFFE, '0, 1'b0);
    check("br_nt_val", bus_a.pc, 32'h0000_0204);

    // Five calls overflow a 4-deep stack, then drain and underflow
    for (int i = 0; i < 5; i++) step($sformatf("call%0d", i), 1'b0, SEQ, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 4; i++) step($sformatf("ret%0d", i), 1'b0, RETURN, 1'b0, '0, '0, 1'b0);
    check("ret4_val", bus_a.pc, 32'h0000_020C);
    step("ret_under", 1'b0, RETURN, 1'b0, '0, '0, 1'b0);
    check("ret_under_val", bus_a.pc, 32'h0000_0210);

    // Stall holds pc and stack; second instance exercises high-region jump+call
    step("pre_stall_call", 1'b0, SEQ, 1'b0, '0, '0, 1'b1);
    bus_b.stall = 1'b0; bus_b.pc_sel = JUMP; bus_b.jump_target = 26'h000_0040; bus_b.call = 1'b1;
    step("stall0", 1'b1, JUMP, 1'b0, '0, 26'h3FF_FFFF, 1'b1);
    check("b_jump:pc", bus_b.pc, 32'h3000_0100);
    check("b_jump:empty", bus_b.ras_empty, 1'b0);
    bus_b.pc_sel = RETURN; bus_b.call = 1'b0;
    step("stall1", 1'b1, JUMP, 1'b0, '0, 26'h3FF_FFFF, 1'b1);
    check("b_ret:pc", bus_b.pc, 32'h3000_0014);
    check("b_ret:empty", bus_b.ras_empty, 1'b1);
    bus_b.stall = 1'b1; bus_b.pc_sel = SEQ;
    step("stall2", 1'b1, JUMP, 1'b0, '0, 26'h3FF_FFFF, 1'b1);
    step("post_stall_ret", 1'b0, RETURN, 1'b0, '0, '0, 1'b0);

    // Asynchronous reset in the middle of a stalled call
    step("call_b4_rst", 1'b0, SEQ, 1'b0, '0, '0, 1'b1);
    step("stall_b4_rst", 1'b1, JUMP, 1'b0, '0, 26'h123, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_rst:pc", bus_a.pc, 32'h0000_0100);
    check("async_rst:ovf", bus_a.ras_overflow, 1'b0);
    check("async_rst:unf", bus_a.ras_underflow, 1'b0);
    check("async_rst:empty", bus_a.ras_empty, 1'b1);
    model_reset();
    #2 reset = 1'b0;
    step("rst_hold", 1'b1, JUMP, 1'b0, '0, 26'h123, 1'b1);

    // Address wrap, then return and call in the same cycle
    step("br_to_top", 1'b0, BRANCH, 1'b1, 16'hFFBE, '0, 1'b0);
    check("br_to_top_val", bus_a.pc, 32'hFFFF_FFFC);
    step("wrap", 1'b0, SEQ, 1'b0, '0, '0, 1'b0);
    check("wrap_val", bus_a.pc, 32'h0000_0000);
    step("link0", 1'b0, SEQ, 1'b0, '0, '0, 1'b1);
    step("link1", 1'b0, SEQ, 1'b0, '0, '0, 1'b1);
    step("ret_call", 1'b0, RETURN, 1'b0, '0, '0, 1'b1);
    check("ret_call_val", bus_a.pc, 32'h0000_0008);
    step("ret_new_top", 1'b0, RETURN, 1'b0, '0, '0, 1'b0);
    check("ret_new_top_val", bus_a.pc, 32'h0000_000C);
    step("ret_base", 1'b0, RETURN, 1'b0, '0, '0, 1'b0);
    step("ret_call_empty", 1'b0, RETURN, 1'b0, '0, '0, 1'b1);
    step("ret_after", 1'b0, RETURN, 1'b0, '0, '0, 1'b0);
    step("br_fwd", 1'b0, BRANCH, 1'b1, 16'h0010, '0, 1'b0);
    check("br_fwd_val", bus_a.pc, 32'h0000_004C);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
